axi_lite_regslice: RTL and testbench



---
 rtl/axi_lite_regslice_if.sv | 42 ++++
 rtl/axi_lite_regslice.sv | 162 ++++++++++++++++
 tb/tb_axi_lite_regslice.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_regslice_if.sv
// AXI-Lite channel bundle. Valid/ready rule: a beat moves on a rising edge where
// valid && ready; once valid is high its payload holds until that edge.
interface axi_lite_channel #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic                      aw_valid;
  logic                      aw_ready;
  logic [ADDR_WIDTH-1:0]     aw_addr;
  logic [2:0]                aw_prot;
  logic                      w_valid;
  logic                      w_ready;
  logic [DATA_WIDTH-1:0]     w_data;
  logic [DATA_WIDTH/8-1:0]   w_strb;
  logic                      b_valid;
  logic                      b_ready;
  logic [1:0]                b_resp;
  logic                      ar_valid;
  logic                      ar_ready;
  logic [ADDR_WIDTH-1:0]     ar_addr;
  logic [2:0]                ar_prot;
  logic                      r_valid;
  logic                      r_ready;
  logic [DATA_WIDTH-1:0]     r_data;
  logic [1:0]                r_resp;

  modport master (
    output aw_valid, aw_addr, aw_prot, input aw_ready,
    output w_valid, w_data, w_strb, input w_ready,
    input b_valid, b_resp, output b_ready,
    output ar_valid, ar_addr, ar_prot, input ar_ready,
    input r_valid, r_data, r_resp, output r_ready
  );

  modport slave (
    input aw_valid, aw_addr, aw_prot, output aw_ready,
    input w_valid, w_data, w_strb, output w_ready,
    output b_valid, b_resp, input b_ready,
    input ar_valid, ar_addr, ar_prot, output ar_ready,
    output r_valid, r_data, r_resp, input r_ready
  );
endinterface

// File: rtl/axi_lite_regslice.sv
// AXI-Lite register slice: each of the five channels is independently a wire,
// a forward register or a two-entry skid buffer.
module axi_lite_regslice_stage #(
  parameter int WIDTH = 1,
  parameter int MODE  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} skid_state_e;

  if (MODE == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk | rst;
    assign out_valid      = in_valid;
    assign out_data       = in_data;
    assign in_ready       = out_ready;
  end else if (MODE == 1) begin : g_fwd
    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    assign in_ready  = !rst && (!valid_q || out_ready);
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
      end else if (in_ready) begin
        valid_q <= in_valid;
        if (in_valid) data_q <= in_data;
      end
    end
  end else if (MODE == 2) begin : g_skid
    skid_state_e      state;
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] s_data;
    logic             in_xfer;
    logic             out_xfer;

    // in_ready comes only from state, so out_ready never reaches the source.
    assign in_ready  = !rst && (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);
    assign out_data  = m_data;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    always_ff @(posedge clk) begin
      if (rst) begin
        state <= ST_EMPTY;
      end else begin
        case (state)
          ST_EMPTY: begin
            if (in_xfer) begin
              m_data <= in_data;
              state  <= ST_ONE;
            end
          end
          ST_ONE: begin
            if (in_xfer && out_xfer) begin
              m_data <= in_data;
            end else if (in_xfer) begin
              s_data <= in_data;
              state  <= ST_FULL;
            end else if (out_xfer) begin
              state  <= ST_EMPTY;
            end
          end
          ST_FULL: begin
            if (out_xfer) begin
              m_data <= s_data;
              state  <= ST_ONE;
            end
          end
          default: state <= ST_EMPTY;
        endcase
      end
    end
  end else begin : g_bad_mode
    $fatal(1, "axi_lite_regslice_stage: MODE must be 0, 1 or 2");
  end
endmodule

module axi_lite_regslice #(
  parameter int AW_MODE = 2,
  parameter int W_MODE  = 2,
  parameter int B_MODE  = 2,
  parameter int AR_MODE = 2,
  parameter int R_MODE  = 2
) (
  input  logic            clk,
  input  logic            rst,
  axi_lite_channel.slave  master,
  axi_lite_channel.master slave
);
  localparam int AW    = $bits(master.aw_addr);
  localparam int DW    = $bits(master.w_data);
  localparam int SW    = $bits(master.w_strb);
  localparam int A_PW  = AW + 3;
  localparam int W_PW  = DW + SW;
  localparam int R_PW  = DW + 2;

  if ($bits(slave.aw_addr) != AW) begin : g_bad_addr
    $fatal(1, "axi_lite_regslice: master/slave ADDR_WIDTH differ");
  end
  if ($bits(slave.w_data) != DW) begin : g_bad_data
    $fatal(1, "axi_lite_regslice: master/slave DATA_WIDTH differ");
  end

  logic [A_PW-1:0] aw_in, aw_out, ar_in, ar_out;
  logic [W_PW-1:0] w_in, w_out;
  logic [1:0]      b_in, b_out;
  logic [R_PW-1:0] r_in, r_out;

  assign aw_in = {master.aw_addr, master.aw_prot};
  assign {slave.aw_addr, slave.aw_prot} = aw_out;
  assign w_in  = {master.w_data, master.w_strb};
  assign {slave.w_data, slave.w_strb} = w_out;
  assign b_in  = slave.b_resp;
  assign master.b_resp = b_out;
  assign ar_in = {master.ar_addr, master.ar_prot};
  assign {slave.ar_addr, slave.ar_prot} = ar_out;
  assign r_in  = {slave.r_data, slave.r_resp};
  assign {master.r_data, master.r_resp} = r_out;

  // Requests run master -> slave, responses slave -> master.
  axi_lite_regslice_stage #(.WIDTH(A_PW), .MODE(AW_MODE)) u_aw (
    .clk(clk), .rst(rst),
    .in_valid(master.aw_valid), .in_ready(master.aw_ready), .in_data(aw_in),
    .out_valid(slave.aw_valid), .out_ready(slave.aw_ready), .out_data(aw_out)
  );

  axi_lite_regslice_stage #(.WIDTH(W_PW), .MODE(W_MODE)) u_w (
    .clk(clk), .rst(rst),
    .in_valid(master.w_valid), .in_ready(master.w_ready), .in_data(w_in),
    .out_valid(slave.w_valid), .out_ready(slave.w_ready), .out_data(w_out)
  );

  axi_lite_regslice_stage #(.WIDTH(2), .MODE(B_MODE)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(slave.b_valid), .in_ready(slave.b_ready), .in_data(b_in),
    .out_valid(master.b_valid), .out_ready(master.b_ready), .out_data(b_out)
  );

  axi_lite_regslice_stage #(.WIDTH(A_PW), .MODE(AR_MODE)) u_ar (
    .clk(clk), .rst(rst),
    .in_valid(master.ar_valid), .in_ready(master.ar_ready), .in_data(ar_in),
    .out_valid(slave.ar_valid), .out_ready(slave.ar_ready), .out_data(ar_out)
  );

  axi_lite_regslice_stage #(.WIDTH(R_PW), .MODE(R_MODE)) u_r (
    .clk(clk), .rst(rst),
    .in_valid(slave.r_valid), .in_ready(slave.r_ready), .in_data(r_in),
    .out_valid(master.r_valid), .out_ready(master.r_ready), .out_data(r_out)
  );
endmodule

// File: tb/tb_axi_lite_regslice.sv
// Bench for axi_lite_regslice: four instances (all-skid, all-forward, all-bypass, mixed)
// flattened into per-lane arrays; lane c = AW, W, B, AR, R.
module tb_axi_lite_regslice;
  localparam int NK = 4;
  localparam int NC = 5;
  // Two bits per lane, lane c of instance k at bit (k*5+c)*2.
  localparam logic [39:0] MODE_TAB = {10'b0110001001, 10'b0000000000,
                                      10'b0101010101, 10'b1010101010};

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic        src_valid [NK][NC];
  logic [35:0] src_data  [NK][NC];
  logic        src_ready [NK][NC];
  logic        snk_valid [NK][NC];
  logic [35:0] snk_data  [NK][NC];
  logic        snk_ready [NK][NC];
  logic [35:0] exp_q [NK][NC][$];

  function automatic int mode_of(input int k, input int c);
    return int'(MODE_TAB[(k*5+c)*2 +: 2]);
  endfunction

  function automatic logic [35:0] pmask(input int c);
    logic [35:0] m;
    case (c)
      0, 3:    m = 36'h7_FFFF_FFFF;
      1:       m = 36'hF_FFFF_FFFF;
      2:       m = 36'h0_0000_0003;
      default: m = 36'h3_FFFF_FFFF;
    endcase
    return m;
  endfunction

  for (genvar k = 0; k < NK; k++) begin : g_dut
    axi_lite_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_if ();
    axi_lite_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_if ();

    axi_lite_regslice #(
      .AW_MODE(mode_of(k, 0)), .W_MODE(mode_of(k, 1)), .B_MODE(mode_of(k, 2)),
      .AR_MODE(mode_of(k, 3)), .R_MODE(mode_of(k, 4))
    ) u_dut (
      .clk(clk), .rst(rst), .master(m_if), .slave(s_if)
    );

    assign m_if.aw_valid = src_valid[k][0];
    assign {m_if.aw_addr, m_if.aw_prot} = src_data[k][0][34:0];
    assign src_ready[k][0] = m_if.aw_ready;
    assign snk_valid[k][0] = s_if.aw_valid;
    assign snk_data[k][0]  = {1'b0, s_if.aw_addr, s_if.aw_prot};
    assign s_if.aw_ready   = snk_ready[k][0];

    assign m_if.w_valid = src_valid[k][1];
    assign {m_if.w_data, m_if.w_strb} = src_data[k][1];
    assign src_ready[k][1] = m_if.w_ready;
    assign snk_valid[k][1] = s_if.w_valid;
    assign snk_data[k][1]  = {s_if.w_data, s_if.w_strb};
    assign s_if.w_ready    = snk_ready[k][1];

    assign s_if.b_valid    = src_valid[k][2];
    assign s_if.b_resp     = src_data[k][2][1:0];
    assign src_ready[k][2] = s_if.b_ready;
    assign snk_valid[k][2] = m_if.b_valid;
    assign snk_data[k][2]  = {34'b0, m_if.b_resp};
    assign m_if.b_ready    = snk_ready[k][2];

    assign m_if.ar_valid = src_valid[k][3];
    assign {m_if.ar_addr, m_if.ar_prot} = src_data[k][3][34:0];
    assign src_ready[k][3] = m_if.ar_ready;
    assign snk_valid[k][3] = s_if.ar_valid;
    assign snk_data[k][3]  = {1'b0, s_if.ar_addr, s_if.ar_prot};
    assign s_if.ar_ready   = snk_ready[k][3];

    assign s_if.r_valid = src_valid[k][4];
    assign {s_if.r_data, s_if.r_resp} = src_data[k][4][33:0];
    assign src_ready[k][4] = s_if.r_ready;
    assign snk_valid[k][4] = {m_if.r_valid};
    assign snk_data[k][4]  = {2'b0, m_if.r_data, m_if.r_resp};
    assign m_if.r_ready    = snk_ready[k][4];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    for (int k = 0; k < NK; k++)
      for (int c = 0; c < NC; c++) begin
        src_valid[k][c] = 1'b0;
        snk_ready[k][c] = 1'b0;
        exp_q[k][c].delete();
      end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < NK; k++)
      for (int c = 0; c < NC; c++) begin
        src_valid[k][c] = 1'b0;
        src_data[k][c]  = '0;
        snk_ready[k][c] = 1'b1;
      end
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < NK; k++)
      for (int c = 0; c < NC; c++) begin
        checks++;
        if (snk_valid[k][c] !== 1'b0)
          $display("FAIL rst_out_valid k=%0d c=%0d got=%b exp=0", k, c, snk_valid[k][c]);
        if (snk_valid[k][c] !== 1'b0) errors++;
        if (mode_of(k, c) != 0) begin
          checks++;
          if (src_ready[k][c] !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_ready k=%0d c=%0d got=%b exp=0", k, c, src_ready[k][c]);
          end
        end
      end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < NK; k++)
      for (int c = 0; c < NC; c++) snk_ready[k][c] = 1'b0;
    #1;
    for (int k = 0; k < NK; k++)
      for (int c = 0; c < NC; c++)
        if (mode_of(k, c) != 0) begin
          checks++;
          if (src_ready[k][c] !== 1'b1 || snk_valid[k][c] !== 1'b0) begin
            errors++;
            $display("FAIL post_rst k=%0d c=%0d in_ready=%b out_valid=%b exp=1/0",
                     k, c, src_ready[k][c], snk_valid[k][c]);
          end
        end
  endtask

  task automatic test_single_write();
    logic [35:0] e;
    drive_idle();
    @(negedge clk);
    src_valid[0][0] = 1'b1; src_data[0][0] = {1'b0, 32'h10, 3'b000};
    src_valid[0][1] = 1'b1; src_data[0][1] = {32'hDEADBEEF, 4'hF};
    snk_ready[0][0] = 1'b1; snk_ready[0][1] = 1'b1;
    exp_q[0][0].push_back({1'b0, 32'h10, 3'b000});
    exp_q[0][1].push_back({32'hDEADBEEF, 4'hF});
    #1;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (src_ready[0][c] !== 1'b1 || snk_valid[0][c] !== 1'b0) begin
        errors++;
        $display("FAIL wr_accept c=%0d in_ready=%b out_valid=%b exp=1/0", c, src_ready[0][c], snk_valid[0][c]);
      end
    end
    @(negedge clk);
    src_valid[0][0] = 1'b0; src_valid[0][1] = 1'b0;
    #1;
    for (int c = 0; c < 2; c++) begin
      e = exp_q[0][c].pop_front();
      checks++;
      if (snk_valid[0][c] !== 1'b1 || snk_data[0][c] !== e) begin
        errors++;
        $display("FAIL wr_out c=%0d valid=%b data=%h exp=1/%h", c, snk_valid[0][c], snk_data[0][c], e);
      end
    end
    @(negedge clk);
    src_valid[0][2] = 1'b1; src_data[0][2] = 36'h2; snk_ready[0][2] = 1'b1;
    exp_q[0][2].push_back(36'h2);
    #1;
    checks++;
    if (snk_valid[0][0] !== 1'b0 || snk_valid[0][1] !== 1'b0 || snk_valid[0][2] !== 1'b0) begin
      errors++;
      $display("FAIL wr_drained aw=%b w=%b b=%b exp=0/0/0", snk_valid[0][0], snk_valid[0][1], snk_valid[0][2]);
    end
    @(negedge clk);
    src_valid[0][2] = 1'b0;
    #1;
    e = exp_q[0][2].pop_front();
    checks++;
    if (snk_valid[0][2] !== 1'b1 || snk_data[0][2] !== e) begin
      errors++;
      $display("FAIL b_resp valid=%b data=%h exp=1/%h", snk_valid[0][2], snk_data[0][2], e);
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int got = 0;
    logic [35:0] e;
    drive_idle();
    for (int t = 0; t < 30 && got < 4; t++) begin
      @(negedge clk);
      if (t == 8) snk_ready[0][3] = 1'b1;
      src_valid[0][3] = (sent < 4);
      src_data[0][3]  = {1'b0, 32'(sent * 4), 3'b000};
      #1;
      if (t == 2) begin
        checks++;
        if (sent != 2) begin
          errors++;
          $display("FAIL bp_accepted got=%0d exp=2", sent);
        end
      end
      if (t >= 2 && t < 8) begin
        checks++;
        if (src_ready[0][3] !== 1'b0 || snk_valid[0][3] !== 1'b1 || snk_data[0][3] !== 36'h0) begin
          errors++;
          $display("FAIL bp_hold t=%0d in_ready=%b out_valid=%b data=%h exp=0/1/0",
                   t, src_ready[0][3], snk_valid[0][3], snk_data[0][3]);
        end
      end
      if (src_valid[0][3] && src_ready[0][3]) begin
        exp_q[0][3].push_back(src_data[0][3]);
        sent++;
      end
      if (snk_valid[0][3] && snk_ready[0][3]) begin
        got++;
        checks++;
        if (exp_q[0][3].size() == 0) begin
          errors++;
          $display("FAIL bp_extra data=%h exp=none", snk_data[0][3]);
        end else begin
          e = exp_q[0][3].pop_front();
          if (snk_data[0][3] !== e) begin
            errors++;
            $display("FAIL bp_order data=%h exp=%h", snk_data[0][3], e);
          end
        end
      end
    end
    src_valid[0][3] = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (got != 4 || exp_q[0][3].size() != 0 || snk_valid[0][3] !== 1'b0) begin
      errors++;
      $display("FAIL bp_count got=%0d left=%0d valid=%b exp=4/0/0", got, exp_q[0][3].size(), snk_valid[0][3]);
    end
    drive_idle();
  endtask

  task automatic test_throughput();
    int sent = 0;
    int got = 0;
    int cycles = 0;
    logic [35:0] e;
    drive_idle();
    snk_ready[1][4] = 1'b1;
    for (int t = 0; t < 40 && got < 16; t++) begin
      @(negedge clk);
      src_valid[1][4] = (sent < 16);
      src_data[1][4]  = {2'b00, 32'(sent), 2'b00};
      #1;
      if (src_valid[1][4] && src_ready[1][4]) begin
        exp_q[1][4].push_back(src_data[1][4]);
        sent++;
      end
      if (snk_valid[1][4] && snk_ready[1][4]) begin
        got++;
        checks++;
        e = (exp_q[1][4].size() != 0) ? exp_q[1][4].pop_front() : 36'hX;
        if (snk_data[1][4] !== e) begin
          errors++;
          $display("FAIL tp_order beat=%0d data=%h exp=%h", got - 1, snk_data[1][4], e);
        end
      end
      cycles = t + 1;
    end
    checks++;
    if (got != 16 || cycles != 17) begin
      errors++;
      $display("FAIL tp_cycles beats=%0d cycles=%0d exp=16/17", got, cycles);
    end
    drive_idle();
  endtask

  task automatic test_bypass();
    logic [63:0] r;
    drive_idle();
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      for (int c = 0; c < NC; c++) begin
        r = {$urandom, $urandom};
        src_valid[2][c] = 1'($urandom_range(0, 1));
        src_data[2][c]  = r[35:0] & pmask(c);
        snk_ready[2][c] = 1'($urandom_range(0, 1));
      end
      #1;
      for (int c = 0; c < NC; c++) begin
        checks++;
        if (snk_valid[2][c] !== src_valid[2][c] || snk_data[2][c] !== src_data[2][c] ||
            src_ready[2][c] !== snk_ready[2][c]) begin
          errors++;
          $display("FAIL bypass c=%0d v=%b d=%h r=%b exp=%b/%h/%b", c, snk_valid[2][c], snk_data[2][c],
                   src_ready[2][c], src_valid[2][c], src_data[2][c], snk_ready[2][c]);
        end
      end
    end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    drive_idle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      src_valid[0][1] = 1'b1;
      src_data[0][1]  = {32'(i + 36'hA0), 4'h3};
    end
    @(negedge clk);
    src_valid[0][1] = 1'b0;
    #1;
    checks++;
    if (src_ready[0][1] !== 1'b0 || snk_valid[0][1] !== 1'b1) begin
      errors++;
      $display("FAIL mid_full in_ready=%b out_valid=%b exp=0/1", src_ready[0][1], snk_valid[0][1]);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (src_ready[0][1] !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_ready got=%b exp=0", src_ready[0][1]);
    end
    @(negedge clk);
    #1;
    checks++;
    if (src_ready[0][1] !== 1'b0 || snk_valid[0][1] !== 1'b0) begin
      errors++;
      $display("FAIL mid_in_rst in_ready=%b out_valid=%b exp=0/0", src_ready[0][1], snk_valid[0][1]);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (src_ready[0][1] !== 1'b1 || snk_valid[0][1] !== 1'b0) begin
      errors++;
      $display("FAIL mid_release in_ready=%b out_valid=%b exp=1/0", src_ready[0][1], snk_valid[0][1]);
    end
    @(negedge clk);
    #1;
    checks++;
    if (snk_valid[0][1] !== 1'b0) begin
      errors++;
      $display("FAIL mid_after valid=%b exp=0", snk_valid[0][1]);
    end
    drive_idle();
  endtask

  task automatic test_random();
    logic        hold [NK][NC];
    logic        pv   [NK][NC];
    logic        prdy [NK][NC];
    logic [35:0] pd   [NK][NC];
    logic [63:0] r;
    logic [35:0] e;
    drive_idle();
    for (int k = 0; k < NK; k++)
      for (int c = 0; c < NC; c++) begin
        hold[k][c] = 1'b0; pv[k][c] = 1'b0; prdy[k][c] = 1'b0; pd[k][c] = '0;
      end
    for (int t = 0; t < 820; t++) begin
      @(negedge clk);
      for (int k = 0; k < NK; k++)
        for (int c = 0; c < NC; c++) begin
          if (!hold[k][c]) begin
            r = {$urandom, $urandom};
            src_valid[k][c] = (t < 800) && ($urandom_range(0, 2) != 0);
            src_data[k][c]  = r[35:0] & pmask(c);
          end
          snk_ready[k][c] = (t >= 800) || ($urandom_range(0, 2) != 0);
        end
      #1;
      for (int k = 0; k < NK; k++)
        for (int c = 0; c < NC; c++) begin
          if (pv[k][c] && !prdy[k][c]) begin
            checks++;
            if (snk_valid[k][c] !== 1'b1 || snk_data[k][c] !== pd[k][c]) begin
              errors++;
              $display("FAIL rnd_stable k=%0d c=%0d v=%b d=%h exp=1/%h", k, c, snk_valid[k][c], snk_data[k][c], pd[k][c]);
            end
          end
          if (src_valid[k][c] && src_ready[k][c]) exp_q[k][c].push_back(src_data[k][c]);
          hold[k][c] = src_valid[k][c] && !src_ready[k][c];
          if (snk_valid[k][c] && snk_ready[k][c]) begin
            checks++;
            if (exp_q[k][c].size() == 0) begin
              errors++;
              $display("FAIL rnd_extra k=%0d c=%0d d=%h exp=none", k, c, snk_data[k][c]);
            end else begin
              e = exp_q[k][c].pop_front();
              if (snk_data[k][c] !== e) begin
                errors++;
                $display("FAIL rnd_data k=%0d c=%0d d=%h exp=%h", k, c, snk_data[k][c], e);
              end
            end
          end
          pv[k][c] = snk_valid[k][c]; prdy[k][c] = snk_ready[k][c]; pd[k][c] = snk_data[k][c];
        end
    end
    for (int k = 0; k < NK; k++)
      for (int c = 0; c < NC; c++) begin
        checks++;
        if (exp_q[k][c].size() != 0) begin
          errors++;
          $display("FAIL rnd_lost k=%0d c=%0d left=%0d exp=0", k, c, exp_q[k][c].size());
        end
      end
    drive_idle();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_single_write();
    test_backpressure();
    test_throughput();
    test_bypass();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time=%0t exp=finish", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
